// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer sequencer: keypad M:SS entry, counter load handshake,
// door-gated 1 Hz count enable, end-of-cook detection, magnetron and beeper drive.
module microwave_timer_ctrl #(
   parameter int BEEP_TICKS = 3
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        tick_1hz,
   input  logic [3:0]  digit,
   input  logic        digit_vld,
   input  logic        start,
   input  logic        stop,
   input  logic        door_closed,
   input  logic        all_zero,
   output logic [11:0] cnt_data,
   output logic        cnt_loadn,
   output logic        cnt_en,
   output logic        mag_on,
   output logic        beep,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE,
      ENTRY,
      LOAD,
      SETTLE,
      COOK,
      PAUSE,
      DONE
   } state_t;

   state_t     state;
   logic [3:0] min_d;
   logic [3:0] tens_d;
   logic [3:0] ones_d;
   logic [3:0] beep_cnt;
   logic       digit_ok;
   logic       start_ok;

   // Start qualification always looks at the pre-shift entry value.
   assign digit_ok = digit_vld && (digit <= 4'd9);
   assign start_ok = ({min_d, tens_d, ones_d} != 12'h000) && (tens_d <= 4'd5) && door_closed;

   // The entry registers are themselves the counter load data.
   assign cnt_data = {min_d, tens_d, ones_d};

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state     <= IDLE;
         min_d     <= 4'd0;
         tens_d    <= 4'd0;
         ones_d    <= 4'd0;
         beep_cnt  <= 4'd0;
         cnt_loadn <= 1'b1;
         cnt_en    <= 1'b0;
         mag_on    <= 1'b0;
         beep      <= 1'b0;
         err       <= 1'b0;
      end else begin
         cnt_loadn <= 1'b1;
         cnt_en    <= 1'b0;
         err       <= 1'b0;
         case (state)
            IDLE, ENTRY: begin
               if (stop) begin
                  state  <= IDLE;
                  min_d  <= 4'd0;
                  tens_d <= 4'd0;
                  ones_d <= 4'd0;
               end else begin
                  if (digit_ok) begin
                     min_d  <= tens_d;
                     tens_d <= ones_d;
                     ones_d <= digit;
                     state  <= ENTRY;
                  end
                  if (start) begin
                     if (start_ok) begin
                        state     <= LOAD;
                        cnt_loadn <= 1'b0;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
            end
            LOAD: begin
               state <= SETTLE;
            end
            SETTLE: begin
               state  <= COOK;
               mag_on <= 1'b1;
            end
            COOK: begin
               // End of cook outranks a door opening or stop in the same cycle.
               if (all_zero) begin
                  state    <= DONE;
                  mag_on   <= 1'b0;
                  beep     <= 1'b1;
                  beep_cnt <= 4'd0;
               end else if (stop || !door_closed) begin
                  state  <= PAUSE;
                  mag_on <= 1'b0;
               end else begin
                  cnt_en <= tick_1hz & door_closed;
               end
            end
            PAUSE: begin
               if (stop) begin
                  state  <= IDLE;
                  min_d  <= 4'd0;
                  tens_d <= 4'd0;
                  ones_d <= 4'd0;
               end else if (start) begin
                  if (door_closed) begin
                     state  <= COOK;
                     mag_on <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            DONE: begin
               // Any key press silences the beeper and is not acted on further.
               if (start || stop || digit_vld) begin
                  state  <= IDLE;
                  beep   <= 1'b0;
                  min_d  <= 4'd0;
                  tens_d <= 4'd0;
                  ones_d <= 4'd0;
               end else if (tick_1hz) begin
                  if (beep_cnt == 4'(BEEP_TICKS - 1)) begin
                     state  <= IDLE;
                     beep   <= 1'b0;
                     min_d  <= 4'd0;
                     tens_d <= 4'd0;
                     ones_d <= 4'd0;
                  end else begin
                     beep_cnt <= beep_cnt + 4'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed scenarios plus random key/door/tick traffic,
// every cycle compared against a mode/keypad-queue reference model.
module tb_microwave_timer_ctrl;

   localparam int BEEP = 3;

   logic        clk = 1'b0;
   logic        clrn;
   logic        tick_1hz;
   logic [3:0]  digit;
   logic        digit_vld;
   logic        start;
   logic        stop;
   logic        door_closed;
   logic        all_zero;
   logic [11:0] cnt_data;
   logic        cnt_loadn;
   logic        cnt_en;
   logic        mag_on;
   logic        beep;
   logic        err;

   int checks   = 0;
   int failures = 0;

   // reference model state
   string       mode;
   int          keys[$];
   int          beepTicks;
   logic        expLoadn, expEn, expMag, expBeep, expErr;

   microwave_timer_ctrl #(.BEEP_TICKS(BEEP)) dut (
      .clk(clk), .clrn(clrn), .tick_1hz(tick_1hz), .digit(digit), .digit_vld(digit_vld),
      .start(start), .stop(stop), .door_closed(door_closed), .all_zero(all_zero),
      .cnt_data(cnt_data), .cnt_loadn(cnt_loadn), .cnt_en(cnt_en), .mag_on(mag_on),
      .beep(beep), .err(err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [11:0] expData();
      return {4'(keys[0]), 4'(keys[1]), 4'(keys[2])};
   endfunction

   task automatic modelReset();
      mode = "idle";
      keys = '{0, 0, 0};
      beepTicks = 0;
      expLoadn = 1'b1; expEn = 1'b0; expMag = 1'b0; expBeep = 1'b0; expErr = 1'b0;
   endtask

   task automatic clearKeys();
      keys = '{0, 0, 0};
   endtask

   // One clock of the cook-timer rules, applied to the inputs present at the edge.
   task automatic modelStep();
      int  secsValue;
      bit  accept;
      expLoadn = 1'b1; expEn = 1'b0; expErr = 1'b0;
      if (mode == "idle" || mode == "entry") begin
         if (stop) begin
            mode = "idle";
            clearKeys();
         end else begin
            secsValue = keys[0] * 100 + keys[1] * 10 + keys[2];
            accept = start && secsValue != 0 && keys[1] <= 5 && door_closed;
            if (digit_vld && digit <= 9) begin
               void'(keys.pop_front());
               keys.push_back(int'(digit));
               mode = "entry";
            end
            if (start && !accept) expErr = 1'b1;
            if (accept) begin
               mode = "load";
               expLoadn = 1'b0;
            end
         end
      end else if (mode == "load") begin
         mode = "settle";
      end else if (mode == "settle") begin
         mode = "cook";
         expMag = 1'b1;
      end else if (mode == "cook") begin
         if (all_zero) begin
            mode = "done"; expMag = 1'b0; expBeep = 1'b1; beepTicks = 0;
         end else if (stop || !door_closed) begin
            mode = "pause"; expMag = 1'b0;
         end else begin
            expEn = tick_1hz;
         end
      end else if (mode == "pause") begin
         if (stop) begin
            mode = "idle";
            clearKeys();
         end else if (start && door_closed) begin
            mode = "cook"; expMag = 1'b1;
         end else if (start) begin
            expErr = 1'b1;
         end
      end else if (mode == "done") begin
         if (start || stop || digit_vld) begin
            mode = "idle"; expBeep = 1'b0; clearKeys();
         end else if (tick_1hz) begin
            beepTicks++;
            if (beepTicks == BEEP) begin
               mode = "idle"; expBeep = 1'b0; clearKeys();
            end
         end
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".cnt_data"}, cnt_data, expData());
      checkOutput({tag, ".cnt_loadn"}, 12'(cnt_loadn), 12'(expLoadn));
      checkOutput({tag, ".cnt_en"}, 12'(cnt_en), 12'(expEn));
      checkOutput({tag, ".mag_on"}, 12'(mag_on), 12'(expMag));
      checkOutput({tag, ".beep"}, 12'(beep), 12'(expBeep));
      checkOutput({tag, ".err"}, 12'(err), 12'(expErr));
   endtask

   // Drive one cycle of inputs, clock it, step the model and compare just after the edge.
   task automatic applyStimulus(input string tag, input logic s, input logic p, input logic dv,
                                input logic [3:0] dg, input logic tk, input logic dr,
                                input logic az);
      start = s; stop = p; digit_vld = dv; digit = dg; tick_1hz = tk;
      door_closed = dr; all_zero = az;
      @(posedge clk);
      modelStep();
      #1;
      checkAll(tag);
   endtask

   task automatic key(input string tag, input logic [3:0] dg);
      applyStimulus(tag, 1'b0, 1'b0, 1'b1, dg, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic idleCycles(input string tag, input int n, input logic tk, input logic dr);
      for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, 1'b0, 4'd0, tk, dr, 1'b0);
   endtask

   initial begin
      clrn = 1'b0;
      start = 1'b0; stop = 1'b0; digit_vld = 1'b0; digit = 4'd0;
      tick_1hz = 1'b0; door_closed = 1'b1; all_zero = 1'b0;
      modelReset();
      #12;
      checkAll("reset");
      clrn = 1'b1;

      // 1: 1:30 entered and started
      key("t1", 4'd1); key("t1", 4'd3); key("t1", 4'd0);
      checkOutput("t1.data130", cnt_data, 12'h130);
      applyStimulus("t1.start", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("t1.loadn_low", 12'(cnt_loadn), 12'd0);
      idleCycles("t1.settle", 2, 1'b0, 1'b1);
      checkOutput("t1.mag_on", 12'(mag_on), 12'd1);
      for (int i = 0; i < 3; i++) begin
         idleCycles("t1.tick", 1, 1'b1, 1'b1);
         idleCycles("t1.gap", 3, 1'b0, 1'b1);
      end
      applyStimulus("t1.stop", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      applyStimulus("t1.cancel", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

      // 2: rejected starts
      key("t2", 4'd0); key("t2", 4'd0); key("t2", 4'd0);
      applyStimulus("t2.zero", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("t2.err_zero", 12'(err), 12'd1);
      key("t2", 4'd0); key("t2", 4'd7); key("t2", 4'd0);
      applyStimulus("t2.tens7", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("t2.err_tens", 12'(err), 12'd1);
      key("t2.bad", 4'd11);
      applyStimulus("t2.stop", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

      // 3: door opened mid-cook, then resumed without reload
      key("t3", 4'd2); key("t3", 4'd0); key("t3", 4'd0);
      applyStimulus("t3.door_open_start", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus("t3.start", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      idleCycles("t3.cook", 3, 1'b1, 1'b1);
      idleCycles("t3.open", 4, 1'b1, 1'b0);
      checkOutput("t3.mag_off", 12'(mag_on), 12'd0);
      applyStimulus("t3.resume_open", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus("t3.resume", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("t3.no_reload", 12'(cnt_loadn), 12'd1);
      idleCycles("t3.cook2", 2, 1'b1, 1'b1);

      // 4: end of cook, beeper for BEEP ticks
      applyStimulus("t4.zero", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("t4.beep", 12'(beep), 12'd1);
      for (int i = 0; i < BEEP; i++) begin
         idleCycles("t4.gap", 2, 1'b0, 1'b1);
         idleCycles("t4.tick", 1, 1'b1, 1'b1);
      end
      checkOutput("t4.beep_off", 12'(beep), 12'd0);
      checkOutput("t4.cleared", cnt_data, 12'h000);

      // 5: start and stop together while paused
      key("t5", 4'd1); key("t5", 4'd0); key("t5", 4'd0);
      applyStimulus("t5.start", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      idleCycles("t5.cook", 3, 1'b0, 1'b1);
      applyStimulus("t5.pause", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      applyStimulus("t5.both", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      idleCycles("t5.after", 2, 1'b0, 1'b1);
      checkOutput("t5.cleared", cnt_data, 12'h000);

      // digit and start together: start judged on old value, load uses shifted value
      key("t5b", 4'd4);
      applyStimulus("t5b.both", 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
      checkOutput("t5b.data", cnt_data, 12'h045);
      idleCycles("t5b.cook", 3, 1'b1, 1'b1);

      // 6: asynchronous reset mid-cook
      #2;
      clrn = 1'b0;
      #1;
      modelReset();
      checkOutput("t6.mag_async", 12'(mag_on), 12'd0);
      checkAll("t6.reset");
      #2;
      clrn = 1'b1;

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         applyStimulus("rand",
                       1'(($urandom % 100) < 12), 1'(($urandom % 100) < 4),
                       1'(($urandom % 100) < 25), 4'($urandom_range(0, 11)),
                       1'(($urandom % 100) < 20), 1'(($urandom % 100) < 92),
                       1'(($urandom % 100) < 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
